alu_scheduler: RTL
==================

# alu_scheduler

Shares the single `ALU_32bit` datapath between two requesters: the integer pipe (port 0) and the address/branch unit (port 1). Arbitrates between them and latches the operands. Supplies the ALU carry-in from an architectural icc register for carry-using ops, and returns result plus flags over a valid/ready response channel. It sits between the decode/issue logic and the ALU instance. It owns the SPARC integer condition codes (icc = {N,Z,V,C}).

## Interface
- `DATA_W`, 32, operand/result width; must match `ALU_32bit`.
- `OP_W`, 6, ALU opcode width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid[1:0]`  in  2  per-port request valid.
- `req_ready[1:0]`  out  2  per-port request accept.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  DATA_W each  operands A/B for port 0/1.
- `req_op0`, `req_op1`  in  OP_W each  ALU opcode.
- `req_usec[1:0]`  in  2  use icc.C as ALU carry-in (else carry-in 0).
- `req_setcc[1:0]`  in  2  write ALU flags to icc on completion.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  1  port that issued the response.
- `rsp_result`  out  DATA_W  ALU result.
- `rsp_flags`  out  4  ALU {N,Z,V,C} for this op, regardless of setcc.
- `icc`  out  4  architectural condition codes {N,Z,V,C}.

## Operation
- FSM states: IDLE, EXEC, DONE. Reset forces IDLE.
- IDLE:
  - Arbiter picks `gnt` among asserted `req_valid`.
  - `req_ready[gnt]`=1, the other port's ready is 0.
  - On handshake, latch A, B, op, usec, setcc and id, then go to EXEC.
- EXEC:
  - The latched operands drive `ALU_32bit`; carry = usec ? icc.C : 0.
  - At the edge, capture result/flags into the response registers.
  - If setcc, write the flags to `icc`.
  - Go to DONE.
- DONE:
  - `rsp_valid`=1; outputs are stable until handshake.
  - On `rsp_ready`, return to IDLE.
- `req_ready`=0 outside IDLE; at most one op is in flight, so an op never sees stale icc.
- Arbitration is round-robin; the pointer toggles to the non-granted port after each accepted request.
- A lone valid port is always granted regardless of the pointer.
- Requesters must hold valid and payload stable until ready.
- Reset values:
  - `req_ready`=0 while `reset`=1.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0, `icc`=0.
  - RR pointer = port 0.
- Reset asserted mid-operation (EXEC or DONE) discards the op: no icc write, no response.

## Timing
- Request handshake in cycle t; `rsp_valid` rises in cycle t+2; minimum latency is 2.
- Next accept is possible at t+3 if `rsp_ready`=1 at t+2. Peak throughput is 1 op / 3 cycles.
- `icc` updates at the EXEC→DONE edge and is visible in DONE. A carry-using op accepted afterward uses the new C.
- `rsp_ready` held low stalls in DONE indefinitely; no request is accepted meanwhile.
- Both valids asserted simultaneously: the pointer's port wins, and the other wins next time.

## Configuration
- `ALU_SCHED_FIXED_PRIO_EN` defined:
  - Port 0 always wins when both are valid.
  - The RR pointer is not implemented.
- Macro not defined: round-robin as above.

## Structure
- Shared package `alu_pkg`:
  - ALU opcode constants (`ALU_ADD`, `ALU_SUB`, …).
  - icc bit indices `ICC_N=3`, `ICC_Z=2`, `ICC_V=1`, `ICC_C=0`.
  - FSM state enum.
- Sub-module `rr_arbiter_2`: 2-way grant with pointer. It is compiled to fixed priority under the macro.
- Instantiates `ALU_32bit` once, port order (result, N, Z, C, V, A, B, opcode, carry).

## Test plan
- Port 0, `ALU_ADD`, A=0x11110000, B=0x11111111, setcc=1 → at t+2: result=0x22221111, rsp_flags=0000, id=0, icc=0000.
- Port 1, `ALU_ADD`, A=0xFFFFFFFF, B=0x00000001, setcc=1, then port 0 `ALU_ADD` with usec=1, A=0, B=0:
  - First op: result 0, icc Z=1, C=1.
  - Second op: result 0x00000001.
- Both ports valid continuously, rsp_ready=1:
  - Round-robin: grants alternate 0,1,0,1, and each handshake is 3 cycles apart.
  - With `ALU_SCHED_FIXED_PRIO_EN`: all grants to port 0.
- rsp_ready held 0 for 5 cycles in DONE → rsp_valid and payload stable, req_ready=0 throughout, and the response is accepted on the first ready cycle.
- setcc=0 op producing result 0 → rsp_flags Z=1, icc unchanged.
- Reset asserted in EXEC → next cycle: rsp_valid=0, icc=0000, and no response is ever produced for that op.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU scheduler slice.
//   - widths of the ALU datapath and opcode
//   - ALU opcode constants (SPARC op3-style encodings)
//   - icc bit indices {N,Z,V,C}
//   - scheduler FSM state enum and latched request payload
package alu_pkg;

   localparam int unsigned ALU_DATA_W = 32;
   localparam int unsigned ALU_OP_W   = 6;
   localparam int unsigned ICC_W      = 4;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 6'h00;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 6'h01;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 6'h02;
   localparam logic [ALU_OP_W-1:0] ALU_XOR = 6'h03;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 6'h04;

   localparam int unsigned ICC_N = 3;
   localparam int unsigned ICC_Z = 2;
   localparam int unsigned ICC_V = 1;
   localparam int unsigned ICC_C = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   // Operation captured at the request handshake
   typedef struct packed {
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
      logic [ALU_OP_W-1:0]   op;
      logic                  usec;
      logic                  setcc;
      logic                  id;
   } alu_req_t;

   // Assemble individual ALU flags into icc order {N,Z,V,C}
   function automatic logic [ICC_W-1:0] pack_flags(input logic n, input logic z,
                                                    input logic v, input logic c);
      return {n, z, v, c};
   endfunction

endpackage

// File: rtl/ALU_32bit.sv
// ALU_32bit: combinational 32-bit integer ALU.
//   result, n, z, c, v : outputs (result and SPARC-style flags)
//   a, b               : operands
//   opcode             : alu_pkg ALU_* encoding
//   carry              : carry-in for ADD (added) and SUB (borrow, subtracted)
// C is carry-out for ADD and borrow for SUB; logical ops clear C and V.
module ALU_32bit
   import alu_pkg::*;
(
   output logic [ALU_DATA_W-1:0] result,
   output logic                  n,
   output logic                  z,
   output logic                  c,
   output logic                  v,
   input  logic [ALU_DATA_W-1:0] a,
   input  logic [ALU_DATA_W-1:0] b,
   input  logic [ALU_OP_W-1:0]   opcode,
   input  logic                  carry
);

   logic [ALU_DATA_W:0] wide;

   // Operation select and arithmetic flags
   always_comb begin
      wide   = '0;
      result = '0;
      c      = 1'b0;
      v      = 1'b0;
      case (opcode)
         ALU_ADD: begin
            wide   = {1'b0, a} + {1'b0, b} + (ALU_DATA_W+1)'(carry);
            result = wide[ALU_DATA_W-1:0];
            c      = wide[ALU_DATA_W];
            v      = (a[ALU_DATA_W-1] == b[ALU_DATA_W-1]) &&
                     (result[ALU_DATA_W-1] != a[ALU_DATA_W-1]);
         end
         ALU_SUB: begin
            wide   = {1'b0, a} - {1'b0, b} - (ALU_DATA_W+1)'(carry);
            result = wide[ALU_DATA_W-1:0];
            c      = wide[ALU_DATA_W];
            v      = (a[ALU_DATA_W-1] != b[ALU_DATA_W-1]) &&
                     (result[ALU_DATA_W-1] != a[ALU_DATA_W-1]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         default: result = '0;
      endcase
   end

   assign n = result[ALU_DATA_W-1];
   assign z = (result == '0);

endmodule

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way request arbiter.
//   clk, reset : clock and synchronous active-high reset (pointer only)
//   req        : per-port request
//   advance    : a grant was accepted this cycle; move the pointer
//   gnt        : one-hot grant, zero when no request
// Default build is round-robin: on contention the pointer's port wins and the
// pointer then moves to the port that lost. With ALU_SCHED_FIXED_PRIO_EN
// defined, port 0 always wins and no pointer exists.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

`ifdef ALU_SCHED_FIXED_PRIO_EN
   logic unused_ok;
   assign unused_ok = ^{clk, reset, advance};

   assign gnt = req[0] ? 2'b01 : {req[1], 1'b0};
`else
   logic ptr;

   // Lone requester always wins; pointer only breaks ties
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
   end

   // Granting port 0 hands priority to port 1 and vice versa
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= 1'b0;
      end else if (advance) begin
         ptr <= gnt[0];
      end
   end
`endif

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one ALU_32bit between the integer pipe (port 0) and
// the address/branch unit (port 1), and owns the icc register {N,Z,V,C}.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : per-port request handshake (ready only in IDLE)
//   req_a*/b*/op*     : per-port operands and opcode
//   req_usec          : use icc.C as ALU carry-in
//   req_setcc         : write the op's flags to icc on completion
//   rsp_valid/ready   : response handshake; rsp_id/result/flags held in DONE
//   icc               : architectural condition codes
// Config macro: ALU_SCHED_FIXED_PRIO_EN selects fixed port-0 priority.
// One op in flight: IDLE (accept) -> EXEC (ALU, icc write) -> DONE (respond).
module alu_scheduler
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = ALU_DATA_W,
   parameter int unsigned OP_W   = ALU_OP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b1,
   input  logic [OP_W-1:0]   req_op0,
   input  logic [OP_W-1:0]   req_op1,
   input  logic [1:0]        req_usec,
   input  logic [1:0]        req_setcc,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic [3:0]        rsp_flags,
   output logic [3:0]        icc
);

   sched_state_t      state;
   alu_req_t          op_q;
   logic [1:0]        gnt;
   logic              accept;
   logic              sel;
   logic [DATA_W-1:0] alu_result;
   logic              alu_n, alu_z, alu_c, alu_v;
   logic              alu_cin;
   logic [3:0]        alu_flags;

   rr_arbiter_2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (accept),
      .gnt     (gnt)
   );

   // Grant is presented as ready only while idle and out of reset
   assign req_ready = (state == IDLE && !reset) ? gnt : 2'b00;
   assign accept    = |req_ready;
   assign sel       = gnt[1];

   assign alu_cin   = op_q.usec & icc[ICC_C];
   assign alu_flags = pack_flags(alu_n, alu_z, alu_v, alu_c);

   ALU_32bit u_alu (
      .result (alu_result),
      .n      (alu_n),
      .z      (alu_z),
      .c      (alu_c),
      .v      (alu_v),
      .a      (op_q.a),
      .b      (op_q.b),
      .opcode (op_q.op),
      .carry  (alu_cin)
   );

   // Scheduler FSM with registered response and icc
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op_q       <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         icc        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q.a     <= sel ? req_a1  : req_a0;
                  op_q.b     <= sel ? req_b1  : req_b0;
                  op_q.op    <= sel ? req_op1 : req_op0;
                  op_q.usec  <= req_usec[sel];
                  op_q.setcc <= req_setcc[sel];
                  op_q.id    <= sel;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_flags  <= alu_flags;
               rsp_id     <= op_q.id;
               rsp_valid  <= 1'b1;
               if (op_q.setcc) begin
                  icc <= alu_flags;
               end
               state <= DONE;
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
